// File: rtl/env_adsr.sv
// env_adsr: per-voice ADSR envelope generator producing a 4-bit amplitude level.
//
// Ports:
//   clk      in   system clock
//   rst      in   synchronous reset, active-high
//   gate     in   note on (1) / note off (0); rise starts Attack, fall starts Release
//   attack   in   [3:0] attack step period  = attack+1 prescaler ticks
//   decay    in   [3:0] decay step period   = decay+1 prescaler ticks
//   sustain  in   [3:0] sustain level
//   rel      in   [3:0] release step period = rel+1 prescaler ticks
//                 ("release" is a reserved word, hence the short name)
//   level    out  [3:0] registered envelope level, feeds the 4x4 multiplier volume operand
//   active   out  registered, 1 whenever the envelope is not IDLE
//
// Parameter PRESC_W: prescaler width, one tick every 2^PRESC_W clk cycles.
//
// Optional macro ENV_ADSR_RETRIG_ZERO_EN: when defined, a gate rise also forces
// the level to 0 (hard retrigger); otherwise Attack continues from the current
// level (legato retrigger).
module env_adsr #(
    parameter int PRESC_W = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       gate,
    input  logic [3:0] attack,
    input  logic [3:0] decay,
    input  logic [3:0] sustain,
    input  logic [3:0] rel,
    output logic [3:0] level,
    output logic       active
);
    typedef enum logic [2:0] {IDLE, ATTACK, DECAY, SUSTAIN, RELEASE} state_t;

    state_t               state_q, state_d;
    logic   [3:0]         level_q, level_d;
    logic   [3:0]         step_cnt_q, step_cnt_d;
    logic   [PRESC_W-1:0] pre_cnt_q, pre_cnt_d;
    logic                 gate_q, active_q;
    logic                 rise, fall, tick, step, stepping;
    logic   [3:0]         rate;

    always_comb begin
        rise      = gate & ~gate_q;
        fall      = ~gate & gate_q;
        tick      = &pre_cnt_q;
        pre_cnt_d = rise ? '0 : pre_cnt_q + 1'b1;
        rate      = (state_q == ATTACK) ? attack : (state_q == DECAY) ? decay : rel;
        stepping  = (state_q == ATTACK) || (state_q == DECAY) || (state_q == RELEASE);
        step      = stepping && tick && (step_cnt_q == rate);
        state_d   = state_q;
        level_d   = level_q;
        if (rise) begin
            state_d = ATTACK;
`ifdef ENV_ADSR_RETRIG_ZERO_EN
            level_d = 4'd0;
`else
            level_d = level_q;
`endif
        end else if (fall && (state_q == ATTACK || state_q == DECAY || state_q == SUSTAIN)) begin
            state_d = RELEASE;
        end else begin
            case (state_q)
                IDLE: level_d = 4'd0;
                ATTACK: begin
                    if (step) begin
                        if (level_q == 4'd15) begin
                            state_d = DECAY;
                        end else begin
                            level_d = level_q + 4'd1;
                            if (level_q == 4'd14) state_d = DECAY;
                        end
                    end
                end
                DECAY: begin
                    // Already at/below target: snap straight to sustain without a step.
                    if (level_q <= sustain) begin
                        state_d = SUSTAIN;
                        level_d = sustain;
                    end else if (step) begin
                        level_d = level_q - 4'd1;
                        if (level_q - 4'd1 == sustain) state_d = SUSTAIN;
                    end
                end
                SUSTAIN: level_d = sustain;
                RELEASE: begin
                    if (level_q == 4'd0) begin
                        state_d = IDLE;
                    end else if (step) begin
                        level_d = level_q - 4'd1;
                        if (level_q == 4'd1) state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
        // A retrigger restarts the stage timing just like a real state change.
        step_cnt_d = (rise || state_d != state_q) ? 4'd0 :
                     !(stepping && tick)          ? step_cnt_q :
                     step                         ? 4'd0 : step_cnt_q + 4'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            level_q    <= 4'd0;
            active_q   <= 1'b0;
            gate_q     <= 1'b0;
            pre_cnt_q  <= '0;
            step_cnt_q <= 4'd0;
        end else begin
            state_q    <= state_d;
            level_q    <= level_d;
            active_q   <= (state_d != IDLE);
            gate_q     <= gate;
            pre_cnt_q  <= pre_cnt_d;
            step_cnt_q <= step_cnt_d;
        end
    end

    assign level  = level_q;
    assign active = active_q;
endmodule

// File: tb/tb_env_adsr.sv
// tb_env_adsr: directed table-driven bench for env_adsr with PRESC_W=2 (tick every 4 cycles).
module tb_env_adsr;
    logic       clk = 1'b0;
    logic       rst, gate;
    logic [3:0] attack, decay, sustain, rel;
    logic [3:0] level;
    logic       active;
    int         errors = 0;
    int         checks = 0;

`ifdef ENV_ADSR_RETRIG_ZERO_EN
    localparam bit RZ = 1'b1;
`else
    localparam bit RZ = 1'b0;
`endif

    typedef struct {
        logic       r;
        logic       g;
        logic [3:0] a, d, s, rl;
        int         n;
        logic [3:0] lv;
        logic       ac;
    } vec_t;

    vec_t vecs[$];

    env_adsr #(.PRESC_W(2)) dut (
        .clk(clk), .rst(rst), .gate(gate), .attack(attack), .decay(decay),
        .sustain(sustain), .rel(rel), .level(level), .active(active)
    );

    always #5 clk = ~clk;

    task automatic add(input logic r, input logic g, input logic [3:0] a, input logic [3:0] d,
                       input logic [3:0] s, input logic [3:0] rl, input int n,
                       input logic [3:0] lv, input logic ac);
        vec_t v;
        v.r = r; v.g = g; v.a = a; v.d = d; v.s = s; v.rl = rl; v.n = n; v.lv = lv; v.ac = ac;
        vecs.push_back(v);
    endtask

    initial begin
        rst = 1'b1; gate = 1'b0; attack = 4'd0; decay = 4'd1; sustain = 4'd8; rel = 4'd0;
        //   r  g  atk dec sus rel  n   level          active
        add(1, 0, 0, 1, 8,  0, 2,  0, 0);                  // reset state
        add(0, 1, 0, 1, 8,  0, 1,  0, 1);                  // E0: rise, active at once
        add(0, 1, 0, 1, 8,  0, 3,  0, 1);                  // E0+3
        add(0, 1, 0, 1, 8,  0, 1,  1, 1);                  // E0+4 first attack step
        add(0, 1, 0, 1, 8,  0, 4,  2, 1);                  // E0+8
        add(0, 1, 0, 1, 8,  0, 52, 15, 1);                 // E0+60 peak, DECAY
        add(0, 1, 0, 1, 8,  0, 7,  15, 1);                 // E0+67 decay=1 -> 8-cycle steps
        add(0, 1, 0, 1, 8,  0, 1,  14, 1);                 // E0+68
        add(0, 1, 0, 1, 8,  0, 47, 9, 1);                  // E0+115
        add(0, 1, 0, 1, 8,  0, 1,  8, 1);                  // E0+116 reach sustain
        add(0, 1, 0, 1, 5,  0, 1,  5, 1);                  // live sustain change
        add(0, 1, 0, 1, 8,  0, 1,  8, 1);
        add(0, 0, 0, 1, 8,  0, 1,  8, 1);                  // E0+119 fall -> RELEASE
        add(0, 0, 0, 1, 8,  0, 1,  7, 1);                  // E0+120 tick
        add(0, 0, 0, 1, 8,  0, 27, 1, 1);                  // E0+147
        add(0, 0, 0, 1, 8,  0, 1,  0, 0);                  // E0+148 reach 0 -> IDLE
        add(0, 1, 0, 0, 8,  0, 1,  0, 1);                  // E1 rise, decay=0
        add(0, 1, 0, 0, 8,  0, 60, 15, 1);                 // E1+60
        add(0, 1, 0, 0, 8,  0, 32, 8, 1);                  // E1+92 in SUSTAIN
        add(0, 0, 0, 0, 8,  0, 8,  6, 1);                  // E1+100 release at 6
        add(0, 1, 0, 0, 8,  0, 1,  RZ ? 4'd0 : 4'd6, 1);   // E2 retrigger
        add(0, 1, 0, 0, 8,  0, 4,  RZ ? 4'd1 : 4'd7, 1);
        add(0, 1, 0, 0, 8,  0, 4,  RZ ? 4'd2 : 4'd8, 1);
        add(0, 1, 0, 0, 15, 0, 56, 15, 1);                 // sustain=15: no decrement
        add(0, 1, 0, 0, 0,  0, 1,  0, 1);                  // sustain=0 followed
        add(0, 1, 0, 0, 0,  0, 20, 0, 1);                  // stays SUSTAIN, active
        add(1, 1, 0, 0, 0,  0, 1,  0, 0);                  // reset with gate high
        add(0, 1, 0, 0, 0,  0, 1,  0, 1);                  // R0: rise seen after reset
        add(0, 1, 0, 0, 0,  0, 36, 9, 1);                  // mid-attack at 9
        add(1, 1, 0, 0, 0,  0, 1,  0, 0);                  // reset mid-attack
        add(0, 1, 0, 0, 0,  0, 1,  0, 1);                  // R1: rise again
        add(0, 1, 0, 0, 0,  0, 4,  1, 1);
        add(0, 0, 0, 0, 0,  0, 1,  1, 1);                  // fall mid-attack
        add(0, 0, 0, 0, 0,  0, 3,  0, 0);                  // release to 0 -> IDLE
        add(0, 1, 0, 0, 0,  0, 1,  0, 1);                  // 1-cycle gate pulse
        add(0, 0, 0, 0, 0,  0, 1,  0, 1);                  // RELEASE at level 0
        add(0, 0, 0, 0, 0,  0, 1,  0, 0);                  // IDLE next edge
        add(0, 1, 1, 0, 0,  0, 1,  0, 1);                  // attack=1 -> 8-cycle steps
        add(0, 1, 1, 0, 0,  0, 7,  0, 1);
        add(0, 1, 1, 0, 0,  0, 1,  1, 1);
        foreach (vecs[i]) begin
            rst = vecs[i].r; gate = vecs[i].g; attack = vecs[i].a;
            decay = vecs[i].d; sustain = vecs[i].s; rel = vecs[i].rl;
            repeat (vecs[i].n) @(posedge clk);
            #1;
            checks++;
            if (level !== vecs[i].lv) begin
                errors++;
                $display("FAIL vec%0d level: got %0d expected %0d", i, level, vecs[i].lv);
            end
            checks++;
            if (active !== vecs[i].ac) begin
                errors++;
                $display("FAIL vec%0d active: got %0b expected %0b", i, active, vecs[i].ac);
            end
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
